hazard_ctrl: RTL and testbench

- Pipeline hazard and stall controller. It generates the stallCtrl/freeze handshake that the decode stage consumes.
- Watches the IF/ID source fields against destination fields in ID/EX, EX/MEM and MEM/WB. Also watches branch resolution, data-memory busy and halt.
- Drives PC, IF/ID and ID/EX enables, bubble insertion and IF/ID flush.
- Holds a small FSM for multi-cycle flush, memory stall and sticky halt.

---
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: PC, IF/ID, ID/EX enables, decode bubble and IF/ID flush; optional perf counters (HAZARD_PERF_EN).
// Latency: control outputs are combinational from FSM state and current inputs; state and counters update on clk.
// Backpressure: memBusy holds PC, IF/ID and ID/EX with no bubble; halt freezes the pipe until rst.
module hazard_ctrl #(
    parameter int RF_BYPASS    = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      instr_IFID,
    input  logic             useRs_IFID,
    input  logic             useRt_IFID,
    input  logic [2:0]       WrR_IDEX,
    input  logic             RegWrite_IDEX,
    input  logic [2:0]       WrR_EXMEM,
    input  logic             RegWrite_EXMEM,
    input  logic [2:0]       WrR_MEMWB,
    input  logic             RegWrite_MEMWB,
    input  logic             takeBranch_EXMEM,
    input  logic             memBusy,
    input  logic             halt_MEMWB,
    output logic             pcEn,
    output logic             ifidEn,
    output logic             freeze,
    output logic             stallCtrl,
    output logic             flush_IFID,
    output logic             halted,
    output logic [CNT_W-1:0] dataStallCnt,
    output logic [CNT_W-1:0] memStallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    // Extra flush cycles still owed after the branch cycle itself
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
    // Without register-file bypass a MEM/WB writer is still a hazard
    localparam logic       MEMWB_HAZ  = (RF_BYPASS == 0);

    state_t     state, state_nxt;
    logic [1:0] fcnt, fcnt_nxt;
    logic [2:0] rs, rt;
    logic       match_rs, match_rt, hazard;
    logic       unused_instr;

    assign rs = instr_IFID[10:8];
    assign rt = instr_IFID[7:5];
    assign unused_instr = ^{instr_IFID[15:11], instr_IFID[4:0]};

    assign match_rs = (RegWrite_IDEX  && (WrR_IDEX  == rs)) ||
                      (RegWrite_EXMEM && (WrR_EXMEM == rs)) ||
                      (MEMWB_HAZ && RegWrite_MEMWB && (WrR_MEMWB == rs));
    assign match_rt = (RegWrite_IDEX  && (WrR_IDEX  == rt)) ||
                      (RegWrite_EXMEM && (WrR_EXMEM == rt)) ||
                      (MEMWB_HAZ && RegWrite_MEMWB && (WrR_MEMWB == rt));
    assign hazard   = (useRs_IFID && match_rs) || (useRt_IFID && match_rt);

    // State and flush-length register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            fcnt  <= 2'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // Priority decode: halt > memBusy > flush > data hazard > run
    always_comb begin
        state_nxt  = state;
        fcnt_nxt   = fcnt;
        pcEn       = 1'b0;
        ifidEn     = 1'b0;
        freeze     = 1'b0;
        stallCtrl  = 1'b0;
        flush_IFID = 1'b0;
        halted     = (state == HALT);
        if ((state == HALT) || halt_MEMWB) begin
            state_nxt = HALT;
        end else if (memBusy) begin
            // everything held, including any flush in progress
            state_nxt = state;
        end else if (takeBranch_EXMEM || (state == FLUSH)) begin
            pcEn       = 1'b1;
            ifidEn     = 1'b1;
            freeze     = 1'b1;
            flush_IFID = 1'b1;
            if (takeBranch_EXMEM) begin
                fcnt_nxt  = FLUSH_LOAD;
                state_nxt = (FLUSH_LOAD != 2'd0) ? FLUSH : RUN;
            end else begin
                fcnt_nxt = fcnt - 2'd1;
                if (fcnt == 2'd1) begin
                    state_nxt = RUN;
                end
            end
        end else if (hazard) begin
            freeze    = 1'b1;
            stallCtrl = 1'b1;
        end else begin
            pcEn   = 1'b1;
            ifidEn = 1'b1;
            freeze = 1'b1;
        end
        if (rst) begin
            pcEn       = 1'b0;
            ifidEn     = 1'b0;
            freeze     = 1'b0;
            stallCtrl  = 1'b0;
            flush_IFID = 1'b0;
            halted     = 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    logic             ev_mem;
    logic [CNT_W-1:0] data_cnt, mem_cnt, flush_cnt;

    // memBusy only counts when it actually owns the cycle (not halting)
    assign ev_mem = memBusy && !halt_MEMWB && (state != HALT) && !rst;

    // Saturating event counters; halted cycles never select a counting case
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_cnt  <= '0;
            mem_cnt   <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallCtrl && (data_cnt != '1)) data_cnt <= data_cnt + 1'b1;
            if (ev_mem && (mem_cnt != '1)) mem_cnt <= mem_cnt + 1'b1;
            if (flush_IFID && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign dataStallCnt = data_cnt;
    assign memStallCnt  = mem_cnt;
    assign flushCnt     = flush_cnt;
`else
    assign dataStallCnt = '0;
    assign memStallCnt  = '0;
    assign flushCnt     = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (bypass/flush-2/16-bit counters and no-bypass/flush-3/3-bit counters) share stimulus.
// Latency: expected outputs are pushed when inputs are driven and popped at the following negedge.
// Backpressure: memBusy and halt sequences exercise the hold paths alongside stalls and flushes.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_IFID;
    logic        useRs_IFID, useRt_IFID;
    logic [2:0]  WrR_IDEX, WrR_EXMEM, WrR_MEMWB;
    logic        RegWrite_IDEX, RegWrite_EXMEM, RegWrite_MEMWB;
    logic        takeBranch_EXMEM, memBusy, halt_MEMWB;

    logic        pcEn0, ifidEn0, freeze0, stallCtrl0, flush0, halted0;
    logic [15:0] dc0, mc0, fc0;
    logic        pcEn1, ifidEn1, freeze1, stallCtrl1, flush1, halted1;
    logic [2:0]  dc1, mc1, fc1;

    always #5 clk = ~clk;

    hazard_ctrl #(.RF_BYPASS(1), .FLUSH_CYCLES(2), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .instr_IFID(instr_IFID),
        .useRs_IFID(useRs_IFID), .useRt_IFID(useRt_IFID),
        .WrR_IDEX(WrR_IDEX), .RegWrite_IDEX(RegWrite_IDEX),
        .WrR_EXMEM(WrR_EXMEM), .RegWrite_EXMEM(RegWrite_EXMEM),
        .WrR_MEMWB(WrR_MEMWB), .RegWrite_MEMWB(RegWrite_MEMWB),
        .takeBranch_EXMEM(takeBranch_EXMEM), .memBusy(memBusy), .halt_MEMWB(halt_MEMWB),
        .pcEn(pcEn0), .ifidEn(ifidEn0), .freeze(freeze0), .stallCtrl(stallCtrl0),
        .flush_IFID(flush0), .halted(halted0),
        .dataStallCnt(dc0), .memStallCnt(mc0), .flushCnt(fc0)
    );

    hazard_ctrl #(.RF_BYPASS(0), .FLUSH_CYCLES(3), .CNT_W(3)) u1 (
        .clk(clk), .rst(rst), .instr_IFID(instr_IFID),
        .useRs_IFID(useRs_IFID), .useRt_IFID(useRt_IFID),
        .WrR_IDEX(WrR_IDEX), .RegWrite_IDEX(RegWrite_IDEX),
        .WrR_EXMEM(WrR_EXMEM), .RegWrite_EXMEM(RegWrite_EXMEM),
        .WrR_MEMWB(WrR_MEMWB), .RegWrite_MEMWB(RegWrite_MEMWB),
        .takeBranch_EXMEM(takeBranch_EXMEM), .memBusy(memBusy), .halt_MEMWB(halt_MEMWB),
        .pcEn(pcEn1), .ifidEn(ifidEn1), .freeze(freeze1), .stallCtrl(stallCtrl1),
        .flush_IFID(flush1), .halted(halted1),
        .dataStallCnt(dc1), .memStallCnt(mc1), .flushCnt(fc1)
    );

    // Expected outputs for one instance in one cycle
    typedef struct packed {
        logic [5:0]  ctl;   // {pcEn, ifidEn, freeze, stallCtrl, flush_IFID, halted}
        logic [15:0] dc;
        logic [15:0] mc;
        logic [15:0] fc;
    } exp_t;

    exp_t sb[$];

    // Reference behaviour per instance
    int P_BYP [2] = '{1, 0};
    int P_FC  [2] = '{2, 3};
    int P_MAX [2] = '{65535, 7};
    bit m_halt [2];
    int m_rem  [2];   // flush cycles still owed after the current one
    int m_dc [2], m_mc [2], m_fc [2];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit writer_matches(input int i, input logic [2:0] r);
        return (RegWrite_IDEX && (WrR_IDEX == r)) ||
               (RegWrite_EXMEM && (WrR_EXMEM == r)) ||
               ((P_BYP[i] == 0) && RegWrite_MEMWB && (WrR_MEMWB == r));
    endfunction

    function automatic int sat_inc(input int v, input int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_halt[i] = 1'b0;
            m_rem[i]  = 0;
            m_dc[i]   = 0;
            m_mc[i]   = 0;
            m_fc[i]   = 0;
        end
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl0"}, {26'd0, pcEn0, ifidEn0, freeze0, stallCtrl0, flush0, halted0}, 32'd0);
        check({tag, "_ctl1"}, {26'd0, pcEn1, ifidEn1, freeze1, stallCtrl1, flush1, halted1}, 32'd0);
        check({tag, "_cnt0"}, {dc0 | mc0 | fc0}, 32'd0);
        check({tag, "_cnt1"}, {dc1 | mc1 | fc1}, 32'd0);
    endtask

    // Asserts rst asynchronously (away from any edge), checks outputs, releases after an edge
    task automatic do_reset();
        rst = 1'b1;
        #2;
        check_reset_outputs("reset");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle();
        instr_IFID       = 16'h0000;
        useRs_IFID       = 1'b0;
        useRt_IFID       = 1'b0;
        WrR_IDEX         = 3'd0;
        WrR_EXMEM        = 3'd0;
        WrR_MEMWB        = 3'd0;
        RegWrite_IDEX    = 1'b0;
        RegWrite_EXMEM   = 1'b0;
        RegWrite_MEMWB   = 1'b0;
        takeBranch_EXMEM = 1'b0;
        memBusy          = 1'b0;
        halt_MEMWB       = 1'b0;
    endtask

    // Unused instruction bits are filled randomly so only [10:8]/[7:5] may matter
    task automatic set_src(input logic [2:0] rs, input logic [2:0] rt, input logic urs, input logic urt);
        logic [15:0] r;
        r          = 16'($urandom);
        instr_IFID = {r[15:11], rs, rt, r[4:0]};
        useRs_IFID = urs;
        useRt_IFID = urt;
    endtask

    // One clock: predict, push, sample at negedge, pop/compare, advance model
    task automatic cycle();
        exp_t e, g;
        bit   n_halt [2];
        int   n_rem [2], n_dc [2], n_mc [2], n_fc [2];
        bit   haz;
        for (int i = 0; i < 2; i++) begin
            haz = (useRs_IFID && writer_matches(i, instr_IFID[10:8])) ||
                  (useRt_IFID && writer_matches(i, instr_IFID[7:5]));
            n_halt[i] = m_halt[i];
            n_rem[i]  = m_rem[i];
            n_dc[i]   = m_dc[i];
            n_mc[i]   = m_mc[i];
            n_fc[i]   = m_fc[i];
            e.dc = PERF ? 16'(m_dc[i]) : 16'd0;
            e.mc = PERF ? 16'(m_mc[i]) : 16'd0;
            e.fc = PERF ? 16'(m_fc[i]) : 16'd0;
            if (m_halt[i] || halt_MEMWB) begin
                e.ctl     = {5'b00000, m_halt[i]};
                n_halt[i] = 1'b1;
            end else if (memBusy) begin
                e.ctl   = 6'b000000;
                n_mc[i] = sat_inc(m_mc[i], P_MAX[i]);
            end else if (takeBranch_EXMEM || (m_rem[i] > 0)) begin
                e.ctl    = 6'b111010;
                n_rem[i] = takeBranch_EXMEM ? P_FC[i] - 1 : m_rem[i] - 1;
                n_fc[i]  = sat_inc(m_fc[i], P_MAX[i]);
            end else if (haz) begin
                e.ctl   = 6'b001100;
                n_dc[i] = sat_inc(m_dc[i], P_MAX[i]);
            end else begin
                e.ctl = 6'b111000;
            end
            sb.push_back(e);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (sb.size() == 0) begin
                check($sformatf("sb_empty%0d_c%0d", i, cyc), 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                if (i == 0) begin
                    g.ctl = {pcEn0, ifidEn0, freeze0, stallCtrl0, flush0, halted0};
                    g.dc  = dc0;
                    g.mc  = mc0;
                    g.fc  = fc0;
                end else begin
                    g.ctl = {pcEn1, ifidEn1, freeze1, stallCtrl1, flush1, halted1};
                    g.dc  = 16'(dc1);
                    g.mc  = 16'(mc1);
                    g.fc  = 16'(fc1);
                end
                check($sformatf("ctl%0d_c%0d", i, cyc), 32'(g.ctl), 32'(e.ctl));
                check($sformatf("dstall%0d_c%0d", i, cyc), 32'(g.dc), 32'(e.dc));
                check($sformatf("mstall%0d_c%0d", i, cyc), 32'(g.mc), 32'(e.mc));
                check($sformatf("flush%0d_c%0d", i, cyc), 32'(g.fc), 32'(e.fc));
            end
        end
        for (int i = 0; i < 2; i++) begin
            m_halt[i] = n_halt[i];
            m_rem[i]  = n_rem[i];
            m_dc[i]   = n_dc[i];
            m_mc[i]   = n_mc[i];
            m_fc[i]   = n_fc[i];
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs(input bit allow_halt);
        set_src(3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
        WrR_IDEX         = 3'($urandom);
        WrR_EXMEM        = 3'($urandom);
        WrR_MEMWB        = 3'($urandom);
        RegWrite_IDEX    = 1'($urandom);
        RegWrite_EXMEM   = 1'($urandom);
        RegWrite_MEMWB   = 1'($urandom);
        takeBranch_EXMEM = ($urandom_range(0, 5) == 0);
        memBusy          = ($urandom_range(0, 4) == 0);
        halt_MEMWB       = allow_halt ? 1'($urandom) : 1'b0;
    endtask

    initial begin
        idle();
        model_reset();
        do_reset();

        // Quiet pipe: everything enabled
        repeat (2) cycle();

        // Load-use: producer r3 walks ID/EX -> EX/MEM -> MEM/WB -> gone
        set_src(3'd3, 3'd6, 1'b1, 1'b0);
        RegWrite_IDEX = 1'b1; WrR_IDEX = 3'd3;
        cycle();
        RegWrite_IDEX = 1'b0; RegWrite_EXMEM = 1'b1; WrR_EXMEM = 3'd3;
        cycle();
        RegWrite_EXMEM = 1'b0; RegWrite_MEMWB = 1'b1; WrR_MEMWB = 3'd3;
        cycle();
        RegWrite_MEMWB = 1'b0;
        cycle();
        check("loaduse_len_byp", 32'(dc0), PERF ? 32'd2 : 32'd0);
        check("loaduse_len_nobyp", 32'(dc1), PERF ? 32'd3 : 32'd0);

        // MEM/WB-only match, unused rt match, used rt match, r0 match
        do_reset();
        idle();
        set_src(3'd5, 3'd1, 1'b1, 1'b0);
        RegWrite_MEMWB = 1'b1; WrR_MEMWB = 3'd5;
        cycle();
        idle();
        set_src(3'd2, 3'd4, 1'b1, 1'b0);
        RegWrite_EXMEM = 1'b1; WrR_EXMEM = 3'd4;
        cycle();
        useRt_IFID = 1'b1;
        cycle();
        idle();
        set_src(3'd0, 3'd7, 1'b1, 1'b1);
        RegWrite_IDEX = 1'b1; WrR_IDEX = 3'd0;
        cycle();
        idle();
        cycle();

        // Taken branch while a hazard is present: flush wins
        do_reset();
        set_src(3'd3, 3'd0, 1'b1, 1'b0);
        RegWrite_IDEX = 1'b1; WrR_IDEX = 3'd3;
        takeBranch_EXMEM = 1'b1;
        cycle();
        takeBranch_EXMEM = 1'b0;
        repeat (2) cycle();
        check("branch_flush_len2", 32'(fc0), PERF ? 32'd2 : 32'd0);
        check("branch_flush_len3", 32'(fc1), PERF ? 32'd3 : 32'd0);
        repeat (2) cycle();
        // Second branch inside the flush window reloads the length
        idle();
        takeBranch_EXMEM = 1'b1;
        cycle();
        cycle();
        takeBranch_EXMEM = 1'b0;
        repeat (4) cycle();

        // memBusy during a data hazard, then the stall resumes
        do_reset();
        set_src(3'd6, 3'd0, 1'b1, 1'b0);
        RegWrite_EXMEM = 1'b1; WrR_EXMEM = 3'd6;
        memBusy = 1'b1;
        repeat (4) cycle();
        memBusy = 1'b0;
        repeat (2) cycle();
        check("membusy_len0", 32'(mc0), PERF ? 32'd4 : 32'd0);
        check("membusy_len1", 32'(mc1), PERF ? 32'd4 : 32'd0);
        // memBusy freezes an in-progress flush
        idle();
        takeBranch_EXMEM = 1'b1;
        cycle();
        takeBranch_EXMEM = 1'b0;
        memBusy = 1'b1;
        repeat (2) cycle();
        memBusy = 1'b0;
        repeat (4) cycle();

        // Long stall: 3-bit counter saturates at 7
        do_reset();
        set_src(3'd1, 3'd1, 1'b0, 1'b1);
        RegWrite_IDEX = 1'b1; WrR_IDEX = 3'd1;
        repeat (10) cycle();
        check("sat_dstall0", 32'(dc0), PERF ? 32'd10 : 32'd0);
        check("sat_dstall1", 32'(dc1), PERF ? 32'd7 : 32'd0);

        // Mixed random traffic without halt
        do_reset();
        repeat (80) begin
            randomize_inputs(1'b0);
            cycle();
        end

        // Halt pulse, then inputs toggle while halted
        randomize_inputs(1'b0);
        halt_MEMWB = 1'b1;
        cycle();
        halt_MEMWB = 1'b0;
        repeat (6) begin
            randomize_inputs(1'b1);
            cycle();
        end
        check("halt_sticky0", 32'(halted0), 32'd1);
        check("halt_sticky1", 32'(halted1), 32'd1);

        // Reset in the middle of a halt clears it asynchronously
        do_reset();
        idle();
        repeat (2) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time bound so a broken DUT can never hang the run
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached (checks %0d, failures %0d)", n_chk, n_fail);
        $fatal(1);
    end

endmodule
